// File: rtl/cnt5_req_arbiter.sv
// cnt5_req_arbiter
// Shares one external 5-bit up/down counter between N_REQ requesters.
// A round-robin arbiter picks one active requester. A three-state FSM
// (IDLE -> EXEC -> DONE) drives exactly one counter strobe for one cycle,
// then returns the updated count with a one-cycle grant pulse.
//
// Optional feature macro: CNT5_ARB_WRAP_EN
//   undefined : up at MAX_CNT and down at zero are refused. The counter is
//               left untouched and err pulses with the grant.
//   defined   : those operations go through. The counter wraps and err
//               stays 0.
//
// Handshake: each requester holds a level on req_up/req_dn/req_clr until it
// sees its gnt bit. The operation is captured only while the FSM is in IDLE.
// Later changes, including a request that drops early, do not affect the
// operation in flight. Every captured operation ends with exactly one gnt
// pulse unless rst intervenes.

module cnt5_req_arbiter #(
  parameter int         N_REQ   = 2,
  parameter logic [4:0] MAX_CNT = 5'd31
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_up,
  input  logic [N_REQ-1:0] req_dn,
  input  logic [N_REQ-1:0] req_clr,
  input  logic [4:0]       cnt_val,
  input  logic             cnt_zero,
  output logic             cntU,
  output logic             cntD,
  output logic             rst5,
  output logic [N_REQ-1:0] gnt,
  output logic [4:0]       rsp_cnt,
  output logic             err,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_CLR  = 2'd1,
    OP_UP   = 2'd2,
    OP_DN   = 2'd3
  } op_t;

  state_t           state_q;
  logic [PW-1:0]    rr_ptr_q;
  logic [PW-1:0]    rr_ptr_d;
  logic [PW-1:0]    winner_q;
  logic             refuse_q;
  logic             cntu_q;
  logic             cntd_q;
  logic             rst5_q;
  logic [N_REQ-1:0] gnt_q;
  logic             err_q;

  logic [N_REQ-1:0] active;
  logic             pick_found;
  logic [PW-1:0]    pick_idx;
  op_t              pick_op;
  logic             pick_refuse;
  logic [N_REQ-1:0] win_oh;
  int               cand;
  int               nxt;

  // Round-robin search: the first active requester at or after rr_ptr wins.
  always_comb begin
    active     = req_up | req_dn | req_clr;
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int off = 0; off < N_REQ; off++) begin
      cand = int'(rr_ptr_q) + off;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!pick_found && active[cand[PW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[PW-1:0];
      end
    end
  end

  // Decode the winner's operation (clr > up > dn) and decide whether it must be refused.
  always_comb begin
    pick_op = OP_NONE;
    if (req_clr[pick_idx])     pick_op = OP_CLR;
    else if (req_up[pick_idx]) pick_op = OP_UP;
    else if (req_dn[pick_idx]) pick_op = OP_DN;
`ifdef CNT5_ARB_WRAP_EN
    // The counter wraps naturally, so no operation is ever refused.
    pick_refuse = 1'b0;
`else
    pick_refuse = ((pick_op == OP_UP) && (cnt_val == MAX_CNT)) ||
                  ((pick_op == OP_DN) && cnt_zero);
`endif
  end

  // Build the one-hot grant vector for the latched winner and the next round-robin start.
  always_comb begin
    win_oh = '0;
    for (int i = 0; i < N_REQ; i++) begin
      win_oh[i] = (winner_q == PW'(i));
    end
    nxt = int'(winner_q) + 1;
    if (nxt >= N_REQ) nxt = 0;
    rr_ptr_d = nxt[PW-1:0];
  end

  // Control FSM. The strobe registers are the latched operation: they are loaded
  // on the IDLE->EXEC edge, so they are high exactly during the EXEC cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      winner_q <= '0;
      refuse_q <= 1'b0;
      cntu_q   <= 1'b0;
      cntd_q   <= 1'b0;
      rst5_q   <= 1'b0;
      gnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      cntu_q <= 1'b0;
      cntd_q <= 1'b0;
      rst5_q <= 1'b0;
      gnt_q  <= '0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pick_found) begin
            winner_q <= pick_idx;
            refuse_q <= pick_refuse;
            state_q  <= ST_EXEC;
            if (!pick_refuse) begin
              rst5_q <= (pick_op == OP_CLR);
              cntu_q <= (pick_op == OP_UP);
              cntd_q <= (pick_op == OP_DN);
            end
          end
        end
        ST_EXEC: begin
          gnt_q   <= win_oh;
          err_q   <= refuse_q;
          state_q <= ST_DONE;
        end
        ST_DONE: begin
          rr_ptr_q <= rr_ptr_d;
          refuse_q <= 1'b0;
          state_q  <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // The counter updates on the edge that ends EXEC, so its value is read live during DONE.
  always_comb begin
    rsp_cnt = (|gnt_q) ? cnt_val : 5'd0;
  end

  assign cntU      = cntu_q;
  assign cntD      = cntd_q;
  assign rst5      = rst5_q;
  assign gnt       = gnt_q;
  assign err       = err_q;
  assign busy      = (state_q != ST_IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_cnt5_req_arbiter.sv
// Directed bench for cnt5_req_arbiter. A behavioural 5-bit counter that can be
// preloaded stands in for counter_5bit. Expectations follow CNT5_ARB_WRAP_EN
// when that macro is defined for the build.
module tb_cnt5_req_arbiter;

  logic       clk;
  logic       rst;
  logic [1:0] req_up;
  logic [1:0] req_dn;
  logic [1:0] req_clr;
  logic [4:0] cnt_val;
  logic       cnt_zero;
  logic       cntU;
  logic       cntD;
  logic       rst5;
  logic [1:0] gnt;
  logic [4:0] rsp_cnt;
  logic       err;
  logic       busy;
  logic [1:0] state_dbg;

  logic       ld;
  logic [4:0] ld_val;

  int n_checks;
  int n_err;

`ifdef CNT5_ARB_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  // Clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counter stand-in: synchronous clear, up, down, plus a preload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt_val <= 5'd0;
    else if (ld)   cnt_val <= ld_val;
    else if (rst5) cnt_val <= 5'd0;
    else if (cntU) cnt_val <= cnt_val + 5'd1;
    else if (cntD) cnt_val <= cnt_val - 5'd1;
  end
  assign cnt_zero = (cnt_val == 5'd0);

  cnt5_req_arbiter #(.N_REQ(2), .MAX_CNT(5'd31)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_up    (req_up),
    .req_dn    (req_dn),
    .req_clr   (req_clr),
    .cnt_val   (cnt_val),
    .cnt_zero  (cnt_zero),
    .cntU      (cntU),
    .cntD      (cntD),
    .rst5      (rst5),
    .gnt       (gnt),
    .rsp_cnt   (rsp_cnt),
    .err       (err),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  task automatic preload(input logic [4:0] v);
    ld     = 1'b1;
    ld_val = v;
    tick();
    ld     = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    rst      = 1'b1;
    req_up   = '0;
    req_dn   = '0;
    req_clr  = '0;
    ld       = 1'b0;
    ld_val   = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    check("rst_cntU", cntU, 0);
    check("rst_cntD", cntD, 0);
    check("rst_rst5", rst5, 0);
    check("rst_gnt", gnt, 0);
    check("rst_rsp", rsp_cnt, 0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
    check("rst_state", state_dbg, 0);
    rst = 1'b0;

    // 1: single up from requester 0; request dropped during EXEC still completes
    req_up = 2'b01;
    tick();
    check("t1_exec_cntU", cntU, 1);
    check("t1_exec_cntD", cntD, 0);
    check("t1_exec_rst5", rst5, 0);
    check("t1_exec_busy", busy, 1);
    check("t1_exec_gnt", gnt, 0);
    check("t1_exec_rsp", rsp_cnt, 0);
    req_up = 2'b00;
    tick();
    check("t1_done_gnt", gnt, 2'b01);
    check("t1_done_rsp", rsp_cnt, 1);
    check("t1_done_err", err, 0);
    check("t1_done_cntU", cntU, 0);
    tick();
    check("t1_idle_gnt", gnt, 0);
    check("t1_idle_rsp", rsp_cnt, 0);
    check("t1_idle_busy", busy, 0);

    // 2: both requesters hold up, grants alternate 01,10,...
    pulse_rst();
    req_up = 2'b11;
    for (int g = 0; g < 6; g++) begin
      tick();
      check("t2_exec_cntU", cntU, 1);
      tick();
      check("t2_gnt", gnt, (g % 2 == 0) ? 2'b01 : 2'b10);
      check("t2_rsp", rsp_cnt, g + 1);
      tick();
      check("t2_idle_gnt", gnt, 0);
    end
    req_up = 2'b00;
    tick();

    // 3: down at zero from requester 1
    pulse_rst();
    req_dn = 2'b10;
    tick();
    check("t3_exec_cntD", cntD, WRAP ? 1 : 0);
    req_dn = 2'b00;
    tick();
    check("t3_gnt", gnt, 2'b10);
    check("t3_rsp", rsp_cnt, WRAP ? 31 : 0);
    check("t3_err", err, WRAP ? 0 : 1);
    tick();

    // 4: up at 31 from requester 0
    preload(5'd31);
    req_up = 2'b01;
    tick();
    check("t4_exec_cntU", cntU, WRAP ? 1 : 0);
    req_up = 2'b00;
    tick();
    check("t4_gnt", gnt, 2'b01);
    check("t4_rsp", rsp_cnt, WRAP ? 0 : 31);
    check("t4_err", err, WRAP ? 0 : 1);
    tick();

    // 5: clr beats up within one requester; a new request during EXEC is ignored
    preload(5'd7);
    req_clr = 2'b01;
    req_up  = 2'b01;
    tick();
    check("t5_exec_rst5", rst5, 1);
    check("t5_exec_cntU", cntU, 0);
    check("t5_exec_cntD", cntD, 0);
    req_clr = 2'b00;
    req_up  = 2'b10;
    tick();
    check("t5_gnt", gnt, 2'b01);
    check("t5_rsp", rsp_cnt, 0);
    check("t5_err", err, 0);
    req_up = 2'b00;
    tick();
    check("t5_idle_busy", busy, 0);

    // 6: reset during EXEC (winner would be 1), then service restarts at requester 0
    req_up = 2'b11;
    tick();
    check("t6_exec_cntU", cntU, 1);
    check("t6_exec_busy", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_cntU", cntU, 0);
    check("t6_rst_gnt", gnt, 0);
    check("t6_rst_state", state_dbg, 0);
    #1;
    rst = 1'b0;
    tick();
    check("t6_exec2_cntU", cntU, 1);
    tick();
    check("t6_gnt", gnt, 2'b01);
    check("t6_rsp", rsp_cnt, 1);
    req_up = 2'b00;
    tick();
    check("t6_idle_gnt", gnt, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
